// File: rtl/parallel_in_serial_out_tx.sv
// -----------------------------------------------------------------------------
// parallel_in_serial_out_tx
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready handshake and shifted out MSB-first, one bit per edge with
// ShiftEn high. This is the transmit end of the serial-in/parallel-out link.
// The receiver shifts in at bit 0 when SerialValid & ShiftEn is high, so after
// WIDTH captures its parallel output equals the word loaded here.
//
// Ports
//   clk          rising-edge clock
//   Reset        synchronous, active-high reset
//   LoadValid    ParallelIn holds a word to send
//   ParallelIn   word to transmit, sampled only at the accepting edge
//   LoadReady    combinational; a word is accepted this cycle if LoadValid
//   ShiftEn      advance one bit at this edge; low holds everything
//   SerialOut    current serial bit (registered), 0 when idle
//   SerialValid  SerialOut carries a live bit
//   Busy         word in flight (same as SerialValid)
//   Done         one-cycle pulse after the last bit of a word is consumed
//
// State  | Meaning
// -------+----------------------------------------------------------------
// IDLE   | no word in flight, ready to load
// SEND   | shifting a word out; cnt counts the bits already consumed
// -----------------------------------------------------------------------------
module parallel_in_serial_out_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             LoadValid,
    input  logic [WIDTH-1:0] ParallelIn,
    output logic             LoadReady,
    input  logic             ShiftEn,
    output logic             SerialOut,
    output logic             SerialValid,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_q;
    logic             done_nxt;
    logic             last_bit;
    logic             accept;

    // The last bit leaves at this edge; a new word may be loaded in the same
    // edge so back-to-back frames have no gap.
    assign last_bit  = (state == SEND) && ShiftEn && (cnt == LAST_BIT);
    assign LoadReady = !Reset && ((state == IDLE) || last_bit);
    assign accept    = LoadValid && LoadReady;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Next state and next datapath values
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        done_nxt  = last_bit;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                    sr_nxt    = ParallelIn;
                    cnt_nxt   = '0;
                end
            end
            SEND: begin
                if (ShiftEn) begin
                    if (cnt == LAST_BIT) begin
                        if (accept) begin
                            state_nxt = SEND;
                            sr_nxt    = ParallelIn;
                        end else begin
                            state_nxt = IDLE;
                            sr_nxt    = '0;
                        end
                        cnt_nxt = '0;
                    end else begin
                        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sr_nxt    = '0;
                cnt_nxt   = '0;
                done_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        SerialOut   = 1'b0;
        SerialValid = 1'b0;
        if (state == SEND) begin
            SerialOut   = sr[WIDTH-1];
            SerialValid = 1'b1;
        end
        Busy = SerialValid;
        Done = done_q;
    end

endmodule

// File: tb/tb_parallel_in_serial_out_tx.sv
module tb_parallel_in_serial_out_tx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             Reset;
    logic             LoadValid;
    logic [WIDTH-1:0] ParallelIn;
    logic             LoadReady;
    logic             ShiftEn;
    logic             SerialOut;
    logic             SerialValid;
    logic             Busy;
    logic             Done;

    int errors = 0;
    int checks = 0;
    int done_count = 0;

    logic             bit_q[$];
    logic [WIDTH-1:0] word_q[$];
    logic [WIDTH-1:0] rx = '0;

    parallel_in_serial_out_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .LoadValid  (LoadValid),
        .ParallelIn (ParallelIn),
        .LoadReady  (LoadReady),
        .ShiftEn    (ShiftEn),
        .SerialOut  (SerialOut),
        .SerialValid(SerialValid),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        word_q.push_back(w);
        for (int i = WIDTH - 1; i >= 0; i--) bit_q.push_back(w[i]);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Paired receiver plus scoreboard: captures bits where the real receiver
    // would, and compares the assembled word whenever Done pulses.
    always @(negedge clk) begin
        if (Reset === 1'b0) begin
            if (Done === 1'b1) begin
                done_count++;
                if (word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: Done high with no word expected at %0t", $time);
                end else begin
                    check("rx_word", 32'(rx), 32'(word_q.pop_front()));
                end
            end
            if (SerialValid === 1'b1 && ShiftEn === 1'b1) begin
                if (bit_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_bit: got %0b with no bit expected at %0t", SerialOut, $time);
                end else begin
                    check("serial_bit", 32'(SerialOut), 32'(bit_q.pop_front()));
                end
                rx = {rx[WIDTH-2:0], SerialOut};
            end
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] w);
        tick();
        LoadValid  = 1'b1;
        ParallelIn = w;
        #1 check("ready_idle", 32'(LoadReady), 32'd1);
        push_word(w);
        tick();
        LoadValid  = 1'b0;
        ParallelIn = ~w;
        #1;
        check("valid_first", 32'(SerialValid), 32'd1);
        check("busy_first", 32'(Busy), 32'd1);
        check("so_msb", 32'(SerialOut), 32'(w[WIDTH-1]));
        check("ready_busy", 32'(LoadReady), 32'd0);
        for (int i = WIDTH - 2; i >= 0; i--) begin
            tick();
            #1 check("so_bit", 32'(SerialOut), 32'(w[i]));
        end
        tick();
        #1;
        check("valid_after", 32'(SerialValid), 32'd0);
        check("done_pulse", 32'(Done), 32'd1);
        check("ready_after", 32'(LoadReady), 32'd1);
        tick();
        #1 check("done_once", 32'(Done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        Reset      = 1'b1;
        LoadValid  = 1'b1;
        ShiftEn    = 1'b1;
        ParallelIn = 4'hE;

        // Reset held two cycles with LoadValid and ShiftEn high
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            check("rst_ready", 32'(LoadReady), 32'd0);
            check("rst_so", 32'(SerialOut), 32'd0);
            check("rst_valid", 32'(SerialValid), 32'd0);
            check("rst_done", 32'(Done), 32'd0);
        end
        tick();
        Reset     = 1'b0;
        LoadValid = 1'b0;
        #1;
        check("ready_after_rst", 32'(LoadReady), 32'd1);
        check("valid_after_rst", 32'(SerialValid), 32'd0);

        // Single word 1011
        send_word(4'b1011);

        // Back-to-back A then 5
        tick();
        LoadValid  = 1'b1;
        ParallelIn = 4'hA;
        #1 check("b2b_ready0", 32'(LoadReady), 32'd1);
        push_word(4'hA);
        tick();
        ParallelIn = 4'h5;
        #1;
        check("b2b_so1", 32'(SerialOut), 32'd1);
        check("b2b_ready1", 32'(LoadReady), 32'd0);
        tick();
        #1;
        check("b2b_so2", 32'(SerialOut), 32'd0);
        check("b2b_ready2", 32'(LoadReady), 32'd0);
        tick();
        #1;
        check("b2b_so3", 32'(SerialOut), 32'd1);
        check("b2b_ready3", 32'(LoadReady), 32'd0);
        tick();
        #1;
        check("b2b_so4", 32'(SerialOut), 32'd0);
        check("b2b_ready4", 32'(LoadReady), 32'd1);
        push_word(4'h5);
        tick();
        LoadValid = 1'b0;
        #1;
        check("b2b_done1", 32'(Done), 32'd1);
        check("b2b_valid_nogap", 32'(SerialValid), 32'd1);
        check("b2b_so5", 32'(SerialOut), 32'd0);
        tick();
        #1;
        check("b2b_so6", 32'(SerialOut), 32'd1);
        check("b2b_done_low", 32'(Done), 32'd0);
        tick();
        #1 check("b2b_so7", 32'(SerialOut), 32'd0);
        tick();
        #1 check("b2b_so8", 32'(SerialOut), 32'd1);
        tick();
        #1;
        check("b2b_done2", 32'(Done), 32'd1);
        check("b2b_valid_end", 32'(SerialValid), 32'd0);

        // Stall: 1100 with ShiftEn low for 3 cycles after the 2nd bit
        tick();
        LoadValid  = 1'b1;
        ParallelIn = 4'hC;
        #1 check("stall_ready0", 32'(LoadReady), 32'd1);
        push_word(4'hC);
        tick();
        LoadValid = 1'b0;
        #1 check("stall_so1", 32'(SerialOut), 32'd1);
        tick();
        #1 check("stall_so2", 32'(SerialOut), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            ShiftEn    = 1'b0;
            LoadValid  = 1'b1;
            ParallelIn = 4'hF;
            #1;
            check("stall_so_hold", 32'(SerialOut), 32'd0);
            check("stall_ready", 32'(LoadReady), 32'd0);
            check("stall_valid", 32'(SerialValid), 32'd1);
        end
        tick();
        ShiftEn   = 1'b1;
        LoadValid = 1'b0;
        #1;
        check("stall_so3", 32'(SerialOut), 32'd0);
        check("stall_ready_resume", 32'(LoadReady), 32'd0);
        tick();
        #1;
        check("stall_so4", 32'(SerialOut), 32'd0);
        check("stall_ready_last", 32'(LoadReady), 32'd1);
        check("stall_no_early_done", 32'(Done), 32'd0);
        tick();
        #1;
        check("stall_done", 32'(Done), 32'd1);
        check("stall_valid_end", 32'(SerialValid), 32'd0);

        // Load pulse while busy: 0011 with 4'hF offered mid-frame
        tick();
        LoadValid  = 1'b1;
        ParallelIn = 4'h3;
        #1 check("busy_ready0", 32'(LoadReady), 32'd1);
        push_word(4'h3);
        tick();
        ParallelIn = 4'hF;
        #1;
        check("busy_ready_mid", 32'(LoadReady), 32'd0);
        check("busy_so1", 32'(SerialOut), 32'd0);
        tick();
        LoadValid = 1'b0;
        #1 check("busy_so2", 32'(SerialOut), 32'd0);
        tick();
        #1 check("busy_so3", 32'(SerialOut), 32'd1);
        tick();
        #1 check("busy_so4", 32'(SerialOut), 32'd1);
        tick();
        #1;
        check("busy_done", 32'(Done), 32'd1);
        check("busy_idle1", 32'(SerialValid), 32'd0);
        tick();
        #1;
        check("busy_idle2", 32'(SerialValid), 32'd0);
        check("busy_done_low", 32'(Done), 32'd0);

        // Reset mid-frame of 1001, then a fresh 0110
        tick();
        LoadValid  = 1'b1;
        ParallelIn = 4'h9;
        #1 check("mid_ready0", 32'(LoadReady), 32'd1);
        push_word(4'h9);
        tick();
        LoadValid = 1'b0;
        #1 check("mid_so1", 32'(SerialOut), 32'd1);
        tick();
        #1 check("mid_so2", 32'(SerialOut), 32'd0);
        tick();
        Reset = 1'b1;
        bit_q.delete();
        word_q.delete();
        #1 check("mid_rst_ready", 32'(LoadReady), 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        check("mid_valid", 32'(SerialValid), 32'd0);
        check("mid_so", 32'(SerialOut), 32'd0);
        check("mid_no_done", 32'(Done), 32'd0);
        check("mid_ready", 32'(LoadReady), 32'd1);
        tick();
        #1 check("mid_no_done2", 32'(Done), 32'd0);
        send_word(4'h6);

        repeat (3) tick();
        check("bits_left", 32'(bit_q.size()), 32'd0);
        check("words_left", 32'(word_q.size()), 32'd0);
        check("done_count", 32'(done_count), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
